// File: rtl/kfps2kb_command_tx.sv
// kfps2kb_command_tx
// Host-to-device PS/2 transmitter. Sends one command byte to the keyboard
// by inhibiting the bus, issuing request-to-send, then shifting the byte
// out LSB-first on device-generated falling clock edges. Odd parity and
// stop bits follow, and the device ACK is sampled on the final edge.
// Both pad outputs are open-drain low-enables (1 = pull low, 0 = release).
//
// Ports
//   clock                   system clock
//   reset_n                 asynchronous active-low reset
//   device_clock            PS/2 clock pad input (asynchronous)
//   device_data             PS/2 data pad input (asynchronous)
//   device_clock_drive_low  1 = pull PS/2 clock low
//   device_data_drive_low   1 = pull PS/2 data low
//   tx_data                 command byte, captured when a request is accepted
//   tx_request              start a transfer (accepted only while idle)
//   tx_busy                 high from the accept cycle until after tx_done
//   tx_done                 one-cycle pulse at the end of every transfer
//   tx_error                qualifies tx_done: no ACK or timeout
module kfps2kb_command_tx #(
  parameter logic [15:0] inhibit_time  = 16'd1000,
  parameter logic [15:0] start_timeout = 16'd20000,
  parameter logic [15:0] over_time     = 16'd1000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       device_clock,
  input  logic       device_data,
  output logic       device_clock_drive_low,
  output logic       device_data_drive_low,
  input  logic [7:0] tx_data,
  input  logic       tx_request,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  typedef enum logic [3:0] {
    IDLE, INHIBIT, START, REQUEST, DATA, STOP, ACK, WAIT_IDLE, DONE
  } state_t;

  state_t      state, state_next;

  // Synchronisers; idle bus level is high, so they reset to 1 to avoid a
  // spurious falling edge when reset is released.
  logic        clk_s1, clk_s2, clk_s3;
  logic        data_s1, data_s2;
  logic        fall;

  logic [8:0]  shift_reg, shift_next;      // {parity, byte}, shifted out LSB first
  logic [3:0]  bit_count, bit_count_next;  // falling edges seen, 1..11
  logic [15:0] timer, timer_next, timer_inc;
  logic        ack_error, ack_next;        // sampled data at edge 11
  logic        result_error, err_next;
  logic        data_low_reg, data_low_next;
  logic        clk_low_reg;
  logic        busy_reg, done_reg, error_reg;

  assign fall = clk_s3 & ~clk_s2;

  assign device_clock_drive_low = clk_low_reg;
  assign device_data_drive_low  = data_low_reg;
  assign tx_busy                = busy_reg;
  assign tx_done                = done_reg;
  assign tx_error               = error_reg;

  // True on the last cycle before the timer reaches lim.
  function automatic logic reached(input logic [15:0] t, input logic [15:0] lim);
    return ({1'b0, t} + 17'd1) >= {1'b0, lim};
  endfunction

  always_comb begin
    state_next     = state;
    shift_next     = shift_reg;
    bit_count_next = bit_count;
    ack_next       = ack_error;
    err_next       = result_error;
    data_low_next  = data_low_reg;
    timer_inc      = (timer == 16'hFFFF) ? timer : timer + 16'd1;

    case (state)
      IDLE: begin
        data_low_next = 1'b0;
        if (tx_request) begin
          state_next     = INHIBIT;
          shift_next     = {~^tx_data, tx_data};
          bit_count_next = 4'd0;
          ack_next       = 1'b1;
          err_next       = 1'b0;
        end
      end
      INHIBIT: begin
        if (reached(timer, inhibit_time)) begin
          state_next    = START;
          data_low_next = 1'b1;   // data goes low together with START
        end
      end
      START: begin
        state_next = REQUEST;   // data stays low as the start bit
      end
      REQUEST: begin
        if (fall) begin
          state_next     = DATA;
          bit_count_next = 4'd1;
          data_low_next  = ~shift_reg[0];
          shift_next     = shift_reg >> 1;
        end else if (reached(timer, start_timeout)) begin
          state_next    = DONE;
          data_low_next = 1'b0;
          err_next      = 1'b1;
        end
      end
      DATA: begin
        if (fall) begin
          bit_count_next = bit_count + 4'd1;
          if (bit_count == 4'd9) begin
            // Edge 10: release data so the line floats high as the stop bit.
            state_next    = STOP;
            data_low_next = 1'b0;
          end else begin
            // Edges 2..9: remaining data bits, then parity.
            data_low_next = ~shift_reg[0];
            shift_next    = shift_reg >> 1;
          end
        end else if (reached(timer, over_time)) begin
          state_next    = DONE;
          data_low_next = 1'b0;
          err_next      = 1'b1;
        end
      end
      STOP: begin
        if (fall) begin
          bit_count_next = bit_count + 4'd1;
          ack_next       = data_s2;
          state_next     = ACK;
        end else if (reached(timer, over_time)) begin
          state_next = DONE;
          err_next   = 1'b1;
        end
      end
      ACK: begin
        err_next   = ack_error;
        state_next = WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (clk_s2 && data_s2) begin
          state_next = DONE;
        end else if (reached(timer, over_time)) begin
          state_next = DONE;
          err_next   = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next    = IDLE;
        data_low_next = 1'b0;
      end
    endcase

    // Edges only restart the timer once the device owns the clock; the
    // host's own inhibit pulse also shows up as a synchronised fall.
    if ((state_next != state) ||
        (fall && (state inside {REQUEST, DATA, STOP, ACK, WAIT_IDLE})))
      timer_next = 16'd0;
    else
      timer_next = timer_inc;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      clk_s1       <= 1'b1;
      clk_s2       <= 1'b1;
      clk_s3       <= 1'b1;
      data_s1      <= 1'b1;
      data_s2      <= 1'b1;
      shift_reg    <= 9'd0;
      bit_count    <= 4'd0;
      timer        <= 16'd0;
      ack_error    <= 1'b0;
      result_error <= 1'b0;
      data_low_reg <= 1'b0;
      clk_low_reg  <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      error_reg    <= 1'b0;
    end else begin
      clk_s1       <= device_clock;
      clk_s2       <= clk_s1;
      clk_s3       <= clk_s2;
      data_s1      <= device_data;
      data_s2      <= data_s1;
      state        <= state_next;
      shift_reg    <= shift_next;
      bit_count    <= bit_count_next;
      timer        <= timer_next;
      ack_error    <= ack_next;
      result_error <= err_next;
      // Outputs are registered from the next state so they line up with it.
      data_low_reg <= data_low_next;
      clk_low_reg  <= (state_next == INHIBIT) || (state_next == START);
      busy_reg     <= (state_next != IDLE);
      done_reg     <= (state_next == DONE);
      error_reg    <= (state_next == DONE) && err_next;
    end
  end

endmodule

// File: tb/tb_kfps2kb_command_tx.sv
module tb_kfps2kb_command_tx;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       model_clk = 1'b1;
  logic       model_data = 1'b1;
  wire        device_clock;
  wire        device_data;
  logic       device_clock_drive_low, device_data_drive_low;
  logic [7:0] tx_data = 8'h00;
  logic       tx_request = 1'b0;
  logic       tx_busy, tx_done, tx_error;

  // Open-drain bus: either side may pull low.
  assign device_clock = model_clk  & ~device_clock_drive_low;
  assign device_data  = model_data & ~device_data_drive_low;

  kfps2kb_command_tx dut (
    .clock                  (clock),
    .reset_n                (reset_n),
    .device_clock           (device_clock),
    .device_data            (device_data),
    .device_clock_drive_low (device_clock_drive_low),
    .device_data_drive_low  (device_data_drive_low),
    .tx_data                (tx_data),
    .tx_request             (tx_request),
    .tx_busy                (tx_busy),
    .tx_done                (tx_done),
    .tx_error               (tx_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [9:0] frame;   // pad data seen at falls 1..10
    logic       err;
    bit         chk_frame;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         done_count = 0;
  int         target = 0;
  logic [9:0] cap_frame = 10'd0;
  bit         in_xfer = 0;
  bit         busy_low_seen = 0;
  bit         busy_chk_pending = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every tx_done.
  always @(negedge clock) begin
    if (busy_chk_pending) begin
      check("busy_after_done", {31'd0, tx_busy}, 32'd0);
      busy_chk_pending = 0;
    end
    if (in_xfer && !tx_busy) busy_low_seen = 1;
    if (reset_n && tx_done) begin
      done_count++;
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("tx_error", {31'd0, tx_error}, {31'd0, e.err});
        if (e.chk_frame) check("frame", {22'd0, cap_frame}, {22'd0, e.frame});
        check("clk_released", {31'd0, device_clock_drive_low}, 32'd0);
        check("data_released", {31'd0, device_data_drive_low}, 32'd0);
        check("busy_at_done", {31'd0, tx_busy}, 32'd1);
        check("busy_held", {31'd0, busy_low_seen}, 32'd0);
        $display("tx done #%0d: frame=0x%03h err=%0b (exp err=%0b)",
                 done_count, cap_frame, tx_error, e.err);
      end
      in_xfer = 0;
      busy_low_seen = 0;
      busy_chk_pending = 1;
    end
  end

  task automatic send(input logic [7:0] d, input logic [9:0] frame, input logic err,
                      input bit chk, input bit push);
    if (push) begin
      exp_t e;
      e.frame = frame; e.err = err; e.chk_frame = chk;
      sb.push_back(e);
      target++;
    end
    cap_frame = 10'd0;
    @(negedge clock);
    tx_data = d;
    tx_request = 1'b1;
    @(negedge clock);
    tx_request = 1'b0;
    tx_data = ~d;     // must be ignored after accept
    in_xfer = 1;
    check("busy_after_accept", {31'd0, tx_busy}, 32'd1);
  endtask

  // Keyboard model: waits for request-to-send, then clocks nfalls edges.
  task automatic run_device(input int nfalls, input bit ack);
    int guard = 0;
    while (!(!device_clock_drive_low && device_data_drive_low) && guard < 30000) begin
      @(negedge clock);
      guard++;
    end
    check("rts_seen", {31'd0, guard < 30000}, 32'd1);
    repeat (10) @(negedge clock);
    for (int k = 1; k <= nfalls; k++) begin
      if (k == 11 && ack) model_data = 1'b0;
      @(negedge clock);
      model_clk = 1'b0;
      repeat (20) @(negedge clock);
      if (k <= 10) cap_frame[k-1] = device_data;
      model_clk = 1'b1;
      repeat (20) @(negedge clock);
      if (k == 11) model_data = 1'b1;
    end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_count < target && n < budget) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    check("done_count", done_count, target);
  endtask

  task automatic measure_inhibit();
    int g = 0;
    int n = 0;
    int s = 0;
    while (!device_clock_drive_low && g < 100) begin
      @(negedge clock);
      g++;
    end
    while (device_clock_drive_low && !device_data_drive_low && n < 5000) begin
      n++;
      @(negedge clock);
    end
    check("inhibit_cycles", n, 32'd1000);
    while (device_clock_drive_low && device_data_drive_low && s < 10) begin
      s++;
      @(negedge clock);
    end
    check("start_cycles", s, 32'd1);
  endtask

  initial begin
    repeat (90000) @(posedge clock);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_clk_low", {31'd0, device_clock_drive_low}, 32'd0);
    check("rst_data_low", {31'd0, device_data_drive_low}, 32'd0);
    check("rst_busy", {31'd0, tx_busy}, 32'd0);
    check("rst_done", {31'd0, tx_done}, 32'd0);
    check("rst_error", {31'd0, tx_error}, 32'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);

    // 1: ED, timing of inhibit/start, ACK ok
    send(8'hED, 10'h3ED, 1'b0, 1, 1);
    fork
      measure_inhibit();
      run_device(11, 1);
    join
    wait_done(3000);

    // 2: F4 (parity 0) and 00 (parity 1)
    send(8'hF4, 10'h2F4, 1'b0, 1, 1);
    run_device(11, 1);
    wait_done(3000);
    send(8'h00, 10'h300, 1'b0, 1, 1);
    run_device(11, 1);
    wait_done(3000);

    // 3: no ACK
    send(8'hF4, 10'h2F4, 1'b1, 1, 1);
    run_device(11, 0);
    wait_done(3000);

    // 4: device never clocks -> start timeout
    send(8'h12, 10'h000, 1'b1, 0, 1);
    begin
      int g = 0;
      int n = 0;
      while (!(!device_clock_drive_low && device_data_drive_low) && g < 3000) begin
        @(negedge clock);
        g++;
      end
      while (!tx_done && n < 25000) begin
        @(negedge clock);
        n++;
      end
      check("rts_timeout_cycles", n, 32'd20000);
    end
    wait_done(100);

    // 5: device stops after fall 4; second request ignored
    send(8'hA5, 10'h000, 1'b1, 0, 1);
    fork
      run_device(4, 1);
      begin
        repeat (1200) @(negedge clock);
        tx_data = 8'h55;
        tx_request = 1'b1;
        @(negedge clock);
        tx_request = 1'b0;
      end
    join
    wait_done(3000);
    repeat (3000) @(negedge clock);
    check("single_transfer", done_count, target);
    check("idle_clk_released", {31'd0, device_clock_drive_low}, 32'd0);

    // 6: reset during DATA, then FF completes normally
    send(8'h00, 10'h000, 1'b0, 0, 0);
    run_device(3, 1);
    check("data_driven_mid", {31'd0, device_data_drive_low}, 32'd1);
    in_xfer = 0;
    #3 reset_n = 1'b0;
    #1;
    check("rst_mid_data", {31'd0, device_data_drive_low}, 32'd0);
    check("rst_mid_clk", {31'd0, device_clock_drive_low}, 32'd0);
    check("rst_mid_busy", {31'd0, tx_busy}, 32'd0);
    check("rst_mid_done", {31'd0, tx_done}, 32'd0);
    repeat (5) @(negedge clock);
    reset_n = 1'b1;
    busy_low_seen = 0;
    repeat (5) @(negedge clock);
    check("no_done_on_reset", done_count, target);
    send(8'hFF, 10'h3FF, 1'b0, 1, 1);
    run_device(11, 1);
    wait_done(3000);
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
